issue_bus_buffer: RTL
=====================

// Module: issue_bus_buffer
// PURPOSE
//   Parametrised multi-lane issue buffer between the issue stage and the reservation stations and ROB.
//   Accepts up to CH issue packets per cycle, holds them in an in-order circular queue of DEPTH entries
//   and presents the oldest CH entries on CH output lanes with per-lane valid/ready handshake.
//   Buffered entries snoop the CDB and wake up their pending source operands in place.
// PARAMETERS
//   XLEN    32  datapath width (address, immediate, data_1, data_2, cdb_data)
//   REG_W   6   register tag width (src_1, src_2, dest)
//   META_W  16  opaque packed {instr_name, instr_type, flags}; stored and forwarded unmodified
//   CH      2   lanes per side; 1..DEPTH
//   DEPTH   8   queue entries; power of two, >= CH
// PORTS
//   clk        in   1           rising-edge clock
//   reset_n    in   1           asynchronous active-low reset
//   flush      in   1           discard all entries (mispredict/exception)
//   in_valid   in   CH          lane i carries a packet; set bits contiguous from lane 0
//   in_ready   out  1           buffer can take a full CH-lane group this cycle
//   in_addr/in_imm/in_data_1/in_data_2  in  CH*XLEN  per-lane packet fields
//   in_valid_1/in_valid_2                in  CH       operand already available
//   in_src_1/in_src_2/in_dest            in  CH*REG_W register tags
//   in_meta                              in  CH*META_W
//   out_*      out  as in_*     same field set, lane i = entry (head+i)
//   out_valid  out  CH          lane i holds a live entry
//   out_ready  in   CH          consumer takes lane i
//   cdb_valid  in   1           result broadcast valid
//   cdb_tag    in   REG_W       result destination tag
//   cdb_data   in   XLEN        result value
// BEHAVIOUR
//   - Reset: head=tail=count=0; out_valid=0; all out_* fields 0; in_ready=1. Applied asynchronously on
//     reset_n low; a packet in flight in that cycle is dropped.
//   - in_ready = (DEPTH - count) >= CH, computed from registered count (no pass-through from out_ready).
//   - Push: when in_ready, the lanes with in_valid set are written at tail..tail+k-1 and tail+=k.
//     The cycle after the push they are visible on the outputs, at earliest.
//     in_valid with in_ready=0 is ignored; the producer holds the packet.
//   - Pop: k_pop = number of leading lanes with out_valid&out_ready (first 0 stops the count);
//     head+=k_pop. A ready on lane j without ready on lane j-1 does not pop lane j.
//   - count_next = count + k_push - k_pop. Pointers wrap modulo DEPTH.
//   - Push and pop in the same cycle are both honoured. A full queue that pops does NOT raise in_ready
//     that cycle.
//   - out_valid[i] = (i < count). Output fields come straight from the storage registers, with no CDB
//     bypass. A lane popped in the same cycle as a matching CDB leaves with the old operand state, so the
//     consumer snoops the CDB itself.
//   - Wakeup: each stored entry with valid_x=0, cdb_valid=1, cdb_tag==src_x and cdb_tag!=0 sets valid_x=1
//     and data_x=cdb_data. This is visible next cycle.
//   - Incoming packets are also matched against the same-cycle CDB before they are written.
//   - Tag 0 never matches.
//   - flush: next cycle count=0, head=tail=0, out_valid=0. It dominates push, pop and wakeup in the same
//     cycle. Stored field contents are don't-care after flush.
//   - No state machine beyond the occupancy and pointer registers; all state updates occur on the
//     rising edge of clk.
// CONFIGURATION
//   ISSUE_BUS_STATS_EN defined adds three outputs:
//     stat_stall_cnt  32  cycles with any in_valid set and in_ready=0
//     stat_issue_cnt  32  total entries popped
//     stat_peak_occ   $clog2(DEPTH+1)  maximum count seen
//   The counters reset to 0 on reset_n and are NOT cleared by flush. The 32-bit counters saturate at
//   all-ones.
//   ISSUE_BUS_STATS_EN undefined: ports and logic are absent; behaviour is otherwise identical.
// TESTING
//   1. Reset, then push 2 lanes (addr 0x100/0x104) -> next cycle out_valid=2'b11 with the same fields,
//      count=2, in_ready=1.
//   2. Fill 8 entries with out_ready=0 -> in_ready=0 at count>=7. Then out_ready=2'b11 with a push held
//      -> count 8->6, and in_ready rises only the cycle after.
//   3. Entry with src_1=5, valid_1=0 buffered; cdb_valid=1, cdb_tag=5, cdb_data=0xDEAD
//      -> next cycle out_valid_1=1, out_data_1=0xDEAD. Repeat with cdb_tag=0 on src 0 -> no change.
//   4. Push with in_src_2=9 in the same cycle as cdb_tag=9, data 0x42 -> the stored entry reads valid_2=1,
//      data_2=0x42.
//   5. out_ready=2'b10 with 2 entries -> no pop, count unchanged. Then flush together with a push
//      -> next cycle out_valid=0, count=0, in_ready=1.
//   6. Pointer wrap: 20 cycles of push-2/pop-2 with incrementing addresses -> output order is strictly
//      in order, no loss or duplication. With ISSUE_BUS_STATS_EN: stat_issue_cnt=40.

Source files
------------

// File: rtl/issue_bus_buffer.sv
// rtl/issue_bus_buffer.sv - multi-lane in-order issue buffer with CDB wakeup
// Optional statistics outputs are enabled with ISSUE_BUS_STATS_EN.
module issue_bus_buffer #(
  parameter int XLEN   = 32,
  parameter int REG_W  = 6,
  parameter int META_W = 16,
  parameter int CH     = 2,
  parameter int DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [CH-1:0]         in_valid,
  output logic                  in_ready,
  input  logic [CH*XLEN-1:0]    in_addr,
  input  logic [CH*XLEN-1:0]    in_imm,
  input  logic [CH*XLEN-1:0]    in_data_1,
  input  logic [CH*XLEN-1:0]    in_data_2,
  input  logic [CH-1:0]         in_valid_1,
  input  logic [CH-1:0]         in_valid_2,
  input  logic [CH*REG_W-1:0]   in_src_1,
  input  logic [CH*REG_W-1:0]   in_src_2,
  input  logic [CH*REG_W-1:0]   in_dest,
  input  logic [CH*META_W-1:0]  in_meta,
  output logic [CH*XLEN-1:0]    out_addr,
  output logic [CH*XLEN-1:0]    out_imm,
  output logic [CH*XLEN-1:0]    out_data_1,
  output logic [CH*XLEN-1:0]    out_data_2,
  output logic [CH-1:0]         out_valid_1,
  output logic [CH-1:0]         out_valid_2,
  output logic [CH*REG_W-1:0]   out_src_1,
  output logic [CH*REG_W-1:0]   out_src_2,
  output logic [CH*REG_W-1:0]   out_dest,
  output logic [CH*META_W-1:0]  out_meta,
  output logic [CH-1:0]         out_valid,
  input  logic [CH-1:0]         out_ready,
  input  logic                  cdb_valid,
  input  logic [REG_W-1:0]      cdb_tag,
  input  logic [XLEN-1:0]       cdb_data
`ifdef ISSUE_BUS_STATS_EN
  ,
  output logic [31:0]                  stat_stall_cnt,
  output logic [31:0]                  stat_issue_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   stat_peak_occ
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   data_1;
    logic [XLEN-1:0]   data_2;
    logic              valid_1;
    logic              valid_2;
    logic [REG_W-1:0]  src_1;
    logic [REG_W-1:0]  src_2;
    logic [REG_W-1:0]  dest;
    logic [META_W-1:0] meta;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  entry_t            in_ent [CH];
  entry_t            rd_ent [CH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, wr_idx;
  logic [CNT_W-1:0]  count_q, count_d, k_push, k_pop;
  logic [CH-1:0]     push_en, pop_en;

  function automatic entry_t snoop(input entry_t e, input logic v,
                                   input logic [REG_W-1:0] tag, input logic [XLEN-1:0] d);
    entry_t r;
    r = e;
    if (v && tag != '0) begin
      if (!r.valid_1 && r.src_1 == tag) begin
        r.valid_1 = 1'b1;
        r.data_1  = d;
      end
      if (!r.valid_2 && r.src_2 == tag) begin
        r.valid_2 = 1'b1;
        r.data_2  = d;
      end
    end
    return r;
  endfunction

  // Registered occupancy only, so in_ready never depends on out_ready.
  assign in_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(CH);

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      in_ent[i].addr    = in_addr[i*XLEN +: XLEN];
      in_ent[i].imm     = in_imm[i*XLEN +: XLEN];
      in_ent[i].data_1  = in_data_1[i*XLEN +: XLEN];
      in_ent[i].data_2  = in_data_2[i*XLEN +: XLEN];
      in_ent[i].valid_1 = in_valid_1[i];
      in_ent[i].valid_2 = in_valid_2[i];
      in_ent[i].src_1   = in_src_1[i*REG_W +: REG_W];
      in_ent[i].src_2   = in_src_2[i*REG_W +: REG_W];
      in_ent[i].dest    = in_dest[i*REG_W +: REG_W];
      in_ent[i].meta    = in_meta[i*META_W +: META_W];
    end
  end

  // Leading-lane masks: the first lane that does not fire stops the group.
  always_comb begin
    push_en = '0;
    pop_en  = '0;
    k_push  = '0;
    k_pop   = '0;
    for (int i = 0; i < CH; i++) begin
      if (i == 0) begin
        push_en[i] = in_valid[i] & in_ready;
        pop_en[i]  = out_valid[i] & out_ready[i];
      end else begin
        push_en[i] = push_en[i-1] & in_valid[i];
        pop_en[i]  = pop_en[i-1] & out_valid[i] & out_ready[i];
      end
      k_push = k_push + CNT_W'(push_en[i]);
      k_pop  = k_pop + CNT_W'(pop_en[i]);
    end
  end

  always_comb begin
    wr_idx = '0;
    for (int e = 0; e < DEPTH; e++) begin
      mem_d[e] = snoop(mem_q[e], cdb_valid, cdb_tag, cdb_data);
    end
    for (int i = 0; i < CH; i++) begin
      wr_idx = tail_q + PTR_W'(i);
      if (push_en[i]) begin
        mem_d[wr_idx] = snoop(in_ent[i], cdb_valid, cdb_tag, cdb_data);
      end
    end
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(k_pop);
      tail_d  = tail_q + PTR_W'(k_push);
      count_d = count_q + k_push - k_pop;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < DEPTH; e++) mem_q[e] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int e = 0; e < DEPTH; e++) mem_q[e] <= mem_d[e];
    end
  end

  // Outputs read storage directly; a lane popped alongside a CDB hit leaves un-woken.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      rd_ent[i]                     = mem_q[head_q + PTR_W'(i)];
      out_valid[i]                  = CNT_W'(i) < count_q;
      out_addr[i*XLEN +: XLEN]      = rd_ent[i].addr;
      out_imm[i*XLEN +: XLEN]       = rd_ent[i].imm;
      out_data_1[i*XLEN +: XLEN]    = rd_ent[i].data_1;
      out_data_2[i*XLEN +: XLEN]    = rd_ent[i].data_2;
      out_valid_1[i]                = rd_ent[i].valid_1;
      out_valid_2[i]                = rd_ent[i].valid_2;
      out_src_1[i*REG_W +: REG_W]   = rd_ent[i].src_1;
      out_src_2[i*REG_W +: REG_W]   = rd_ent[i].src_2;
      out_dest[i*REG_W +: REG_W]    = rd_ent[i].dest;
      out_meta[i*META_W +: META_W]  = rd_ent[i].meta;
    end
  end

`ifdef ISSUE_BUS_STATS_EN
  logic [31:0]      stall_q, issue_q;
  logic [32:0]      issue_sum;
  logic [CNT_W-1:0] peak_q;

  assign issue_sum = {1'b0, issue_q} + 33'(k_pop);

  // Counters survive flush; only reset_n clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      issue_q <= '0;
      peak_q  <= '0;
    end else begin
      if (|in_valid && !in_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (!flush) issue_q <= issue_sum[32] ? '1 : issue_sum[31:0];
      if (count_q > peak_q) peak_q <= count_q;
    end
  end

  assign stat_stall_cnt = stall_q;
  assign stat_issue_cnt = issue_q;
  assign stat_peak_occ  = peak_q;
`endif

endmodule
